// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - per-core instruction fetch responder with optional direct-mapped cache
//
// Purpose: answers the scheduler's FETCH request by reading one instruction
// from the program memory controller (or from the cache when FETCH_CACHE_EN
// is defined) and reporting completion on fetcher_state.
//
// Optional feature macro: FETCH_CACHE_EN (cache array, tag compare, flush).
//
// Ports:
//   clk, reset_n        core clock, asynchronous active-low reset
//   core_state          scheduler state (IDLE=000 FETCH=001 DECODE=010 DONE=111)
//   current_pc          address of the instruction to fetch
//   cache_flush         invalidate every cache line (unused without the cache)
//   mem_read_valid      read request to program memory, held until ready
//   mem_read_address    request address, held until ready
//   mem_read_ready      memory response strobe, data valid in the same cycle
//   mem_read_data       returned instruction
//   fetcher_state       IDLE=000 FETCHING=001 FETCHED=010
//   instruction         last fetched instruction, stable until the next fetch completes
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_IDLE   = 3'b000;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    localparam logic [2:0] CORE_DONE   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_FETCHING = 3'b001,
        ST_FETCHED  = 3'b010
    } fetch_state_t;

    fetch_state_t                     r_state;
    fetch_state_t                     w_state_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
    logic                             r_abort;

    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
    logic                             w_issue;
    logic                             w_capture;
    logic                             w_load_hit;
    logic                             w_abort_now;

    assign w_abort_now = (core_state == CORE_IDLE) || (core_state == CORE_DONE);

`ifdef FETCH_CACHE_EN
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    logic [PROGRAM_MEM_DATA_BITS-1:0] r_line_data  [CACHE_LINES];
    logic [TAG_BITS-1:0]              r_line_tag   [CACHE_LINES];
    logic [CACHE_LINES-1:0]           r_line_valid;

    logic [IDX_BITS-1:0]              w_lookup_idx;
    logic [TAG_BITS-1:0]              w_lookup_tag;
    logic [IDX_BITS-1:0]              w_fill_idx;
    logic [TAG_BITS-1:0]              w_fill_tag;

    assign w_lookup_idx = current_pc[IDX_BITS-1:0];
    assign w_lookup_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    // Fill from the latched request address: current_pc may already have moved on.
    assign w_fill_idx   = r_addr[IDX_BITS-1:0];
    assign w_fill_tag   = r_addr[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

    // A flush in the lookup cycle forces a miss so stale lines are never returned.
    assign w_hit      = r_line_valid[w_lookup_idx] &&
                        (r_line_tag[w_lookup_idx] == w_lookup_tag) &&
                        !cache_flush;
    assign w_hit_data = r_line_data[w_lookup_idx];

    // Flush takes priority over a same-cycle fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_valid <= '0;
        end else if (cache_flush) begin
            r_line_valid <= '0;
        end else if (w_capture) begin
            r_line_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_line_data[w_fill_idx] <= mem_read_data;
            r_line_tag[w_fill_idx]  <= w_fill_tag;
        end
    end
`else
    logic w_unused_flush;

    assign w_unused_flush = cache_flush;
    assign w_hit          = 1'b0;
    assign w_hit_data     = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_load_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (w_hit) begin
                        w_state_next = ST_FETCHED;
                        w_load_hit   = 1'b1;
                    end else begin
                        w_state_next = ST_FETCHING;
                        w_issue      = 1'b1;
                    end
                end
            end
            ST_FETCHING: begin
                // The handshake cannot be cancelled; an aborted fetch waits for
                // ready and then throws the data away.
                if (mem_read_ready) begin
                    if (r_abort || w_abort_now) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_FETCHED;
                        w_capture    = 1'b1;
                    end
                end
            end
            ST_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_instr <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_addr <= current_pc;
            end
            if (w_capture) begin
                r_instr <= mem_read_data;
            end else if (w_load_hit) begin
                r_instr <= w_hit_data;
            end
            // Sticky: once the scheduler leaves FETCH the result is unwanted.
            r_abort <= (w_state_next == ST_FETCHING) &&
                       (r_abort || ((r_state == ST_FETCHING) && w_abort_now));
        end
    end

    // Decoded from the state register so reset drops the request without a clock.
    assign mem_read_valid   = (r_state == ST_FETCHING);
    assign mem_read_address = r_addr;
    assign fetcher_state    = r_state;
    assign instruction      = r_instr;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - scoreboard bench for instruction_fetcher
module tb_instruction_fetcher;

    logic        clk;
    logic        reset_n;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        cache_flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    localparam logic [2:0] C_IDLE   = 3'b000;
    localparam logic [2:0] C_FETCH  = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;

    int n_vectors;
    int n_miscompares;

    logic [15:0] q_exp[$];
    logic [15:0] last_instr;

    // Reference cache: one entry per index holding full pc and data.
    logic [7:0]  m_pc   [8];
    logic [15:0] m_data [8];
    logic [7:0]  m_v;

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .CACHE_LINES(8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .cache_flush      (cache_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_pop_compare(input string tag);
        logic [15:0] e;
        if (q_exp.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            check_eq(tag, {16'd0, instruction}, {16'd0, e});
            last_instr = e;
        end
    endtask

    // One complete fetch: FETCH, optional memory handshake, then DECODE.
    task automatic do_fetch(input logic [7:0] pc, input logic [15:0] data, input int delay,
                            input logic flush_fill, input logic flush_lookup);
        logic hit;
        int   idx;
        idx = int'(pc[2:0]);
`ifdef FETCH_CACHE_EN
        hit = m_v[idx] && (m_pc[idx] == pc) && !flush_lookup;
`else
        hit = 1'b0;
`endif
        @(negedge clk);
        core_state  = C_FETCH;
        current_pc  = pc;
        cache_flush = flush_lookup;
        if (flush_lookup) m_v = '0;
        if (hit) begin
            q_exp.push_back(m_data[idx]);
            @(posedge clk); #1;
            cache_flush = 1'b0;
            check_eq("hit_no_req", {31'd0, mem_read_valid}, 32'd0);
            check_eq("hit_state", {29'd0, fetcher_state}, 32'd2);
            sb_pop_compare("hit_instr");
        end else begin
            @(posedge clk); #1;
            cache_flush = 1'b0;
            check_eq("miss_valid", {31'd0, mem_read_valid}, 32'd1);
            check_eq("miss_addr", {24'd0, mem_read_address}, {24'd0, pc});
            check_eq("miss_state", {29'd0, fetcher_state}, 32'd1);
            for (int i = 1; i < delay; i++) begin
                @(posedge clk); #1;
                check_eq("hold_valid", {31'd0, mem_read_valid}, 32'd1);
                check_eq("hold_addr", {24'd0, mem_read_address}, {24'd0, pc});
            end
            @(negedge clk);
            mem_read_ready = 1'b1;
            mem_read_data  = data;
            cache_flush    = flush_fill;
            q_exp.push_back(data);
            @(posedge clk); #1;
            mem_read_ready = 1'b0;
            mem_read_data  = 16'($urandom);
            cache_flush    = 1'b0;
            check_eq("done_valid", {31'd0, mem_read_valid}, 32'd0);
            check_eq("done_state", {29'd0, fetcher_state}, 32'd2);
            sb_pop_compare("miss_instr");
            if (flush_fill) begin
                m_v = '0;
            end else begin
                m_v[idx]    = 1'b1;
                m_pc[idx]   = pc;
                m_data[idx] = data;
            end
        end
        @(negedge clk);
        core_state = C_DECODE;
        @(posedge clk); #1;
        check_eq("decode_idle", {29'd0, fetcher_state}, 32'd0);
        check_eq("decode_instr", {16'd0, instruction}, {16'd0, last_instr});
        @(negedge clk);
        core_state = C_IDLE;
    endtask

    initial begin
        n_vectors      = 0;
        n_miscompares  = 0;
        last_instr     = 16'h0000;
        m_v            = '0;
        reset_n        = 1'b0;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        cache_flush    = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", {29'd0, fetcher_state}, 32'd0);
        check_eq("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        check_eq("rst_addr", {24'd0, mem_read_address}, 32'd0);
        check_eq("rst_instr", {16'd0, instruction}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic miss, then repeat (hit with the cache, miss without it).
        do_fetch(8'h05, 16'h9123, 3, 1'b0, 1'b0);
        do_fetch(8'h05, 16'h1111, 2, 1'b0, 1'b0);
        // Conflict on index 5, then a hit on the new tag.
        do_fetch(8'h0D, 16'h4567, 1, 1'b0, 1'b0);
        do_fetch(8'h0D, 16'h7777, 1, 1'b0, 1'b0);
        do_fetch(8'h05, 16'h9124, 2, 1'b0, 1'b0);
        // Explicit flush while idle.
        @(negedge clk);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        m_v = '0;
        do_fetch(8'h0D, 16'h89AB, 2, 1'b0, 1'b0);
        // Flush coinciding with the fill: line must stay invalid.
        do_fetch(8'h07, 16'h2222, 1, 1'b1, 1'b0);
        do_fetch(8'h07, 16'h3333, 1, 1'b0, 1'b0);

        // Abort: scheduler leaves FETCH, ready data must be discarded.
        @(negedge clk);
        core_state = C_FETCH;
        current_pc = 8'h20;
        @(posedge clk); #1;
        check_eq("abort_req", {31'd0, mem_read_valid}, 32'd1);
        @(negedge clk);
        core_state = C_IDLE;
        @(posedge clk); #1;
        check_eq("abort_hold_valid", {31'd0, mem_read_valid}, 32'd1);
        check_eq("abort_hold_addr", {24'd0, mem_read_address}, 32'h20);
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        @(posedge clk); #1;
        mem_read_ready = 1'b0;
        check_eq("abort_state", {29'd0, fetcher_state}, 32'd0);
        check_eq("abort_valid", {31'd0, mem_read_valid}, 32'd0);
        check_eq("abort_instr", {16'd0, instruction}, {16'd0, last_instr});
        do_fetch(8'h20, 16'h5A5A, 2, 1'b0, 1'b0);
        // Flush during a lookup that would otherwise hit.
        do_fetch(8'h20, 16'h6B6B, 1, 1'b0, 1'b1);

        // Loop-body style repeats over a few addresses, including 0xFF.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] pc;
                pc = (k == 3) ? 8'hFF : 8'(8'h40 + k);
                do_fetch(pc, 16'(16'hC000 + 16'(pass * 16) + 16'(k)),
                         1 + int'($urandom_range(0, 2)), 1'b0, 1'b0);
            end
        end

        // Asynchronous reset between edges while a request is outstanding.
        @(negedge clk);
        core_state = C_FETCH;
        current_pc = 8'h33;
        @(posedge clk); #1;
        check_eq("prereset_valid", {31'd0, mem_read_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {31'd0, mem_read_valid}, 32'd0);
        check_eq("async_rst_state", {29'd0, fetcher_state}, 32'd0);
        check_eq("async_rst_instr", {16'd0, instruction}, 32'd0);
        core_state = C_IDLE;
        m_v        = '0;
        last_instr = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        do_fetch(8'h05, 16'hABCD, 1, 1'b0, 1'b0);
        do_fetch(8'h05, 16'hDCBA, 1, 1'b0, 1'b0);

        check_eq("sb_drained", q_exp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Per-core instruction fetch responder that answers the scheduler's fetch request. When the scheduler enters the FETCH state, this block reads the 16-bit instruction at `current_pc` from the program memory controller and reports completion through `fetcher_state`, the signal the scheduler polls. It sits between the scheduler/decoder and the program memory controller port for its core. It optionally contains a small direct-mapped instruction cache.

## Interface
Parameters:
- `PROGRAM_MEM_ADDR_BITS`, 8: program address width; must match `current_pc`.
- `PROGRAM_MEM_DATA_BITS`, 16: instruction width.
- `CACHE_LINES`, 8: number of cache entries; power of two, at least 2; used only with `FETCH_CACHE_EN`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `core_state`  in  3  `corestate_t` from the scheduler; IDLE=000, FETCH=001, DECODE=010, DONE=111.
- `current_pc`  in  8  address of the instruction to fetch.
- `cache_flush`  in  1  invalidates all cache lines; asserted by the dispatcher at kernel start; ignored without the macro.
- `mem_read_valid`  out  1  read request to the program memory controller.
- `mem_read_address`  out  8  request address.
- `mem_read_ready`  in  1  controller response strobe; data is valid in the same cycle.
- `mem_read_data`  in  16  returned instruction.
- `fetcher_state`  out  3  IDLE=000, FETCHING=001, FETCHED=010.
- `instruction`  out  16  last fetched instruction; held stable until the next fetch completes.

## Operation
- **IDLE**
  - Leaves IDLE only when `core_state`==FETCH.
  - Cache hit (macro on): load `instruction` from the hit line and go to FETCHED. No memory request is issued.
  - Miss, or macro off: drive `mem_read_valid`=1 and `mem_read_address`=`current_pc`, then go to FETCHING.
- **FETCHING**
  - `mem_read_valid` and `mem_read_address` are held constant until `mem_read_ready`=1.
  - On `mem_read_ready`=1: capture `mem_read_data` into `instruction`, drop valid, and go to FETCHED.
  - The same capture writes the cache line at index `pc[log2(CACHE_LINES)-1:0]` with the remaining upper PC bits as tag, and sets that line's valid bit.
- **FETCHED**
  - Holds until `core_state`==DECODE, then returns to IDLE.
- **Abort**
  - If `core_state` becomes IDLE or DONE while FETCHING, the outstanding request still completes, because the memory handshake cannot be aborted.
  - On that `mem_read_ready`, the data is discarded: `instruction` and the cache are unchanged, and the state goes directly to IDLE.
- **Request hygiene**
  - `mem_read_valid` is never asserted outside FETCHING.
  - At most one request is outstanding.
- **Address width**
  - No address arithmetic is performed. PC wrap-around from 255 to 0 is handled by the scheduler, and the fetcher fetches whatever address it is given.

## Timing
- **Reset values:** `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, all cache valid bits=0.
- **Reset mid-request:** the request is dropped immediately. The memory controller is reset from the same `reset_n`.
- **Miss latency:** FETCH sampled at edge N gives `mem_read_valid`=1 after N. `mem_read_ready` sampled at edge M gives FETCHED and the new `instruction` after M, so total fetch time is (M−N)+1 cycles with M≥N+1.
- **Hit latency:** FETCH sampled at edge N gives FETCHED after N, a single cycle.
- **Return to idle:** FETCHED to IDLE one cycle after DECODE is sampled.
- **Flush and fill in the same cycle:** flush wins and the line remains invalid. `instruction` is still updated.
- **Flush during a hit lookup in IDLE:** the lookup is treated as a miss.

## Configuration
- `FETCH_CACHE_EN` defined:
  - The cache array, tag compare, and `cache_flush` logic are compiled in.
  - Repeated PCs such as loop bodies complete in 1 cycle.
- `FETCH_CACHE_EN` undefined:
  - No cache storage is built and `cache_flush` is unused.
  - Every fetch goes to memory, so minimum fetch latency is 2 cycles.

## Test plan
- **Basic miss:** reset, `core_state`=FETCH, `current_pc`=0x05, `mem_read_ready` asserted 3 cycles after valid with data 0x9123. Required: `mem_read_address`=0x05 held throughout, `instruction`=0x9123, `fetcher_state`=010 after the ready edge. Then `core_state`=DECODE returns the state to 000 after one cycle.
- **Hit (macro on):** fetch PC 0x05 again after the basic miss. Required: `mem_read_valid` stays 0 and `fetcher_state`=010 one cycle after FETCH, with `instruction`=0x9123.
- **Conflict and flush:** fetch 0x0D, which maps to the same index as 0x05 with 8 lines. Required: a miss and a refill. Then assert `cache_flush` and fetch 0x0D again. Required: a memory request is issued.
- **Abort:** go to FETCHING at PC 0x20, switch `core_state` to IDLE, then give ready with 0xFFFF. Required: `instruction` unchanged, state=IDLE, and a later fetch of 0x20 misses.
- **Async reset mid-FETCHING:** assert `reset_n`=0 between clock edges. Required: `mem_read_valid`=0 and `fetcher_state`=000 immediately, without waiting for `clk`.
- **Macro off:** repeat the hit scenario. Required: a memory request is issued every time.
